// File: rtl/bs_pkg.sv
// Shared types and constants for the backing-store responder memory.
package bs_pkg;

  localparam logic BS_READ  = 1'b0;
  localparam logic BS_WRITE = 1'b1;

  localparam int unsigned BS_LATENCY_DEF = 3;
  localparam int unsigned BS_CNT_W       = 4;

  typedef enum logic [1:0] {
    BS_IDLE = 2'd0,
    BS_BUSY = 2'd1,
    BS_DONE = 2'd2
  } bs_state_e;

  // Request fields as latched at the capture edge
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        typ;
  } bs_req_t;

endpackage

// File: rtl/bs_mem_array.sv
// Single-port synchronous word array: write enable, registered read, async clear.
module bs_mem_array #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_rdata <= '0;
    end else begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end
      if (i_re) begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/bs_responder_mem.sv
// Fixed-latency word memory answering the cache req_do/req_done handshake.
// Define BS_RANGE_CHECK_EN to add req_err and reject addresses beyond DEPTH.
module bs_responder_mem
  import bs_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = BS_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic        req_type,
  input  logic        req_do,
  output logic [31:0] O_data,
  output logic        req_done
`ifdef BS_RANGE_CHECK_EN
  ,
  output logic        req_err
`endif
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  bs_state_e           r_state;
  bs_state_e           w_state_nxt;
  logic [BS_CNT_W-1:0] r_cnt;
  logic [BS_CNT_W-1:0] w_cnt_nxt;
  bs_req_t             r_req;
  logic                w_capture;
  logic                w_access;
  logic                w_oor;
  logic                w_we;
  logic                w_re;
  logic [ADDR_W-1:0]   w_idx;
  logic [31:0]         w_rdata;
  logic                w_unused;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= BS_IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_req <= '{addr: req_addr, data: req_data, typ: req_type};
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      BS_IDLE: begin
        if (req_do) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = BS_CNT_W'(LATENCY - 1);
          w_state_nxt = BS_BUSY;
        end
      end
      BS_BUSY: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - BS_CNT_W'(1);
        end else begin
          w_access    = 1'b1;
          w_state_nxt = BS_DONE;
        end
      end
      BS_DONE: w_state_nxt = BS_IDLE;
      default: w_state_nxt = BS_IDLE;
    endcase
  end

  assign w_idx = r_req.addr[ADDR_W+1:2];

`ifdef BS_RANGE_CHECK_EN
  assign w_oor = |r_req.addr[31:ADDR_W+2];
`else
  // Upper address bits alias onto the array
  assign w_oor = 1'b0;
`endif
  assign w_unused = ^{r_req.addr[31:ADDR_W+2], r_req.addr[1:0]};

  assign w_we = w_access && (r_req.typ == BS_WRITE) && !w_oor;
  assign w_re = w_access && (r_req.typ == BS_READ) && !w_oor;

  bs_mem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (reset),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_idx),
    .i_wdata (r_req.data),
    .o_rdata (w_rdata)
  );

  // Outputs decode registered state only
  assign req_done = (r_state == BS_DONE);
  assign O_data   = (req_done && (r_req.typ == BS_READ) && !w_oor) ? w_rdata : '0;
`ifdef BS_RANGE_CHECK_EN
  assign req_err  = req_done && w_oor;
`endif

endmodule

// File: doc/bs_responder_mem.md
Name: bs_responder_mem

Overview:
Word-addressed memory that answers the cache's backing-store request interface. It is the responder end of the req_do/req_done handshake driven by the cache's miss, write-through and flush paths. It has a configurable, fixed access latency, so cache miss and write timing can be exercised on the PULPino top level. It sits directly under the cache and is the only consumer of the cache's backing-store requests.

Parameters:
DEPTH, 256, number of 32-bit words; must be a power of 2, minimum 2.
ADDR_W, log2(DEPTH) = 8, word-index width; derived, not overridden.
LATENCY, 3, cycles from request capture to access; minimum 1, maximum 15.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req_addr  input  32  byte address; word index = req_addr[ADDR_W+1:2].
req_data  input  32  write data.
req_type  input  1  0 = read, 1 = write.
req_do  input  1  request strobe; one-cycle pulse from the requester.
O_data  output  32  read data; valid only while req_done=1, otherwise 0.
req_done  output  1  one-cycle completion pulse.
req_err  output  1  present only with BS_RANGE_CHECK_EN; see Optional Feature.

Behaviour:
- Reset (asynchronous, active-high): state=Idle, cnt=0, latched addr/data/type=0, rdata=0, all memory words=0. Outputs O_data=0, req_done=0, req_err=0.
- Reset mid-operation: the request is dropped, any pending write is discarded and no req_done is produced.
- FSM states: Idle, Busy, Done.
  - Idle: if req_do is sampled at edge k, latch req_addr, req_data and req_type, set cnt=LATENCY-1, go to Busy.
  - Busy: if cnt!=0, decrement cnt. If cnt==0, perform the access at this edge and go to Done.
    - Write: mem[idx] <= latched data.
    - Read: rdata <= mem[idx].
  - Done: req_done=1. O_data=rdata for reads, 0 for writes. Go to Idle at the next edge unconditionally.
- Timing: req_done is high exactly in the cycle following edge k+LATENCY. With LATENCY=1, req_done rises one cycle after the capture edge.
- req_do in Busy or Done is ignored: not queued, no error. The earliest new capture is the edge after Done.
- req_addr[1:0] is ignored; there are no byte enables.
- req_addr and req_data are sampled only at the capture edge. Later changes have no effect.
- Read-after-write to the same index in consecutive transactions returns the new data.
- O_data and req_done are registered-state decodes, with no combinational path from the inputs.
- The memory has a single port; only one access occurs per transaction.

Optional Feature:
Macro BS_RANGE_CHECK_EN.
- With the macro:
  - A request is out of range when latched addr[31:ADDR_W+2] != 0.
  - An out-of-range write does not modify memory.
  - An out-of-range read returns O_data=0.
  - req_err=1 in the same cycle as req_done; otherwise req_err=0.
- Without the macro: the req_err port is absent, upper address bits are ignored, and addresses alias modulo DEPTH words.

Decomposition:
- Shared package bs_pkg:
  - Request-type constants BS_READ=1'b0 and BS_WRITE=1'b1.
  - FSM state encodings BS_IDLE, BS_BUSY, BS_DONE.
  - Default LATENCY.
- One sub-module, bs_mem_array: single-port synchronous array with write enable, registered read and asynchronous clear on reset.
- FSM, latency counter and range check stay in bs_responder_mem.

Test Plan:
1. Assert then release reset, then read addr 0x0000_0000 -> O_data=0 and req_done=0 throughout reset; after release, req_done pulses once with O_data=0x0000_0000.
2. LATENCY=4: write 0x0000_0010 with data 0xCAFEF00D, then read 0x0000_0010 -> each req_done is high for exactly one cycle, following capture edge +4; the read returns 0xCAFEF00D.
3. Write 0x0000_0014 with data 0x12345678, then read 0x0000_0017 -> O_data=0x12345678, since the low address bits are ignored.
4. Read 0x0000_0010, then pulse req_do during Busy with a write to 0x0000_0020, data 0xFFFFFFFF -> only one req_done occurs; a later read of 0x0000_0020 returns 0.
5. Write 0x0000_0020 with data 0xFFFFFFFF and assert reset while in Busy -> no req_done; after release, a read of 0x0000_0020 returns 0x00000000.
6. DEPTH=256, write 0x0000_0400 with data 0xA5A5A5A5, then read 0x0000_0000:
   - With BS_RANGE_CHECK_EN: the write pulses req_err=1 with req_done; the read returns 0.
   - Without BS_RANGE_CHECK_EN: the read returns 0xA5A5A5A5 (aliasing).
